// File: rtl/reg_file_rd_pkg.sv
// Shared constants for the reg_file_rd register file slice.
// Optional build macro: REG_ZERO_HARDWIRED_EN (register 0 reads as zero).
package reg_file_rd_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_NREGS  = 2 ** DEF_ADDR_W;

    // Index of the register that can be hardwired to zero
    localparam int REG_ZERO = 0;

    // Value loaded into every storage word and read register on reset
    localparam int DATA_RST = 0;

endpackage

// File: rtl/reg_file_rd_reg_word.sv
// One storage word of the register file: write-enabled capture on the
// rising clock edge, asynchronous active-high clear.
module reg_word
    import reg_file_rd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Hold the stored word, loading new data only when this word is written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= DATA_W'(DATA_RST);
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file_rd.sv
// Register file with one write port and two registered read ports.
// Reads have one cycle of latency, a valid strobe, and see a same-edge
// write to the addressed register (write-to-read bypass).
// Optional build macro: REG_ZERO_HARDWIRED_EN -- register 0 has no
// storage, always reads 0 and ignores writes.
module reg_file_rd
    import reg_file_rd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREGS  = 2 ** ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WADDR,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              RE,
    input  logic [ADDR_W-1:0] RADDR_A,
    input  logic [ADDR_W-1:0] RADDR_B,
    output logic [DATA_W-1:0] RDATA_A,
    output logic [DATA_W-1:0] RDATA_B,
    output logic              RVALID
);

`ifdef REG_ZERO_HARDWIRED_EN
    localparam int FIRST_REG = REG_ZERO + 1;
`else
    localparam int FIRST_REG = REG_ZERO;
`endif

    logic [DATA_W-1:0] reg_q [NREGS];
    logic [DATA_W-1:0] next_a;
    logic [DATA_W-1:0] next_b;

`ifdef REG_ZERO_HARDWIRED_EN
    // Register 0 is a constant, so it needs no storage word
    assign reg_q[REG_ZERO] = DATA_W'(DATA_RST);
`endif

    genvar i;
    generate
        for (i = FIRST_REG; i < NREGS; i++) begin : g_word
            reg_word #(
                .DATA_W (DATA_W)
            ) u_word (
                .clk (CLK),
                .rst (RST),
                .we  (WE && (WADDR == ADDR_W'(i))),
                .d   (WDATA),
                .q   (reg_q[i])
            );
        end
    endgenerate

    // Select the value each port will capture, preferring a same-edge write
    always_comb begin
        next_a = reg_q[RADDR_A];
        next_b = reg_q[RADDR_B];
        if (WE && (WADDR == RADDR_A)) begin
            next_a = WDATA;
        end
        if (WE && (WADDR == RADDR_B)) begin
            next_b = WDATA;
        end
`ifdef REG_ZERO_HARDWIRED_EN
        if (RADDR_A == ADDR_W'(REG_ZERO)) begin
            next_a = DATA_W'(DATA_RST);
        end
        if (RADDR_B == ADDR_W'(REG_ZERO)) begin
            next_b = DATA_W'(DATA_RST);
        end
`endif
    end

    // Capture read results on a request and strobe RVALID for one cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RDATA_A <= DATA_W'(DATA_RST);
            RDATA_B <= DATA_W'(DATA_RST);
            RVALID  <= 1'b0;
        end else begin
            RVALID <= RE;
            if (RE) begin
                RDATA_A <= next_a;
                RDATA_B <= next_b;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_rd.sv
// Self-checking bench for reg_file_rd: directed steps from the test plan
// followed by random traffic, compared against an array-based model.
module tb_reg_file_rd;

`ifdef REG_ZERO_HARDWIRED_EN
    localparam bit ZERO_HW = 1'b1;
`else
    localparam bit ZERO_HW = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       WE = 1'b0;
    logic [2:0] WADDR = '0;
    logic [7:0] WDATA = '0;
    logic       RE = 1'b0;
    logic [2:0] RADDR_A = '0;
    logic [2:0] RADDR_B = '0;
    logic [7:0] RDATA_A;
    logic [7:0] RDATA_B;
    logic       RVALID;

    logic [7:0] mem [8];
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic       exp_v;

    int checks = 0;
    int errors = 0;

    reg_file_rd dut (
        .CLK     (CLK),
        .RST     (RST),
        .WE      (WE),
        .WADDR   (WADDR),
        .WDATA   (WDATA),
        .RE      (RE),
        .RADDR_A (RADDR_A),
        .RADDR_B (RADDR_B),
        .RDATA_A (RDATA_A),
        .RDATA_B (RDATA_B),
        .RVALID  (RVALID)
    );

    // 10-unit clock
    always #5 CLK = ~CLK;

    task automatic clearModel();
        for (int k = 0; k < 8; k++) mem[k] = 8'h00;
        exp_a = 8'h00;
        exp_b = 8'h00;
        exp_v = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (RDATA_A === exp_a) else begin
            errors++;
            $error("[TB] FAIL %s rdata_a observed=%h expected=%h", tag, RDATA_A, exp_a);
        end
        checks++;
        assert (RDATA_B === exp_b) else begin
            errors++;
            $error("[TB] FAIL %s rdata_b observed=%h expected=%h", tag, RDATA_B, exp_b);
        end
        checks++;
        assert (RVALID === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s rvalid observed=%b expected=%b", tag, RVALID, exp_v);
        end
    endtask

    // Drive one cycle of inputs, advance the model by one edge, then check
    task automatic applyStimulus(input logic we, input logic [2:0] wa,
                                 input logic [7:0] wd, input logic re,
                                 input logic [2:0] ra, input logic [2:0] rb,
                                 input string tag);
        @(negedge CLK);
        WE = we; WADDR = wa; WDATA = wd;
        RE = re; RADDR_A = ra; RADDR_B = rb;
        @(posedge CLK);
        // A write lands first, so a same-edge read observes the new word
        if (we && !(ZERO_HW && wa == 3'd0)) mem[wa] = wd;
        if (re) begin
            exp_a = mem[ra];
            exp_b = mem[rb];
        end
        exp_v = re;
        #1;
        checkOutput(tag);
    endtask

    initial begin
        clearModel();
        $display("[TB] start, REG_ZERO_HARDWIRED_EN=%0d", ZERO_HW);

        // Power-on reset
        RST = 1'b1;
        #12;
        checkOutput("reset_state");
        @(negedge CLK);
        RST = 1'b0;

        // Write r3 then read it so outputs are nonzero before reset
        applyStimulus(1, 3'd3, 8'hA5, 0, 3'd0, 3'd0, "wr_r3");
        applyStimulus(0, 3'd0, 8'h00, 1, 3'd3, 3'd3, "rd_r3_pre");

        // Mid-cycle asynchronous reset, observed before the next edge
        #2;
        RST = 1'b1;
        WE = 1'b1; WADDR = 3'd4; WDATA = 8'h77; RE = 1'b1;
        #1;
        clearModel();
        checkOutput("async_reset");
        @(negedge CLK);
        RST = 1'b0;
        WE = 1'b0; RE = 1'b0;
        applyStimulus(0, 3'd0, 8'h00, 1, 3'd3, 3'd3, "rd_r3_post_reset");
        applyStimulus(0, 3'd0, 8'h00, 1, 3'd4, 3'd4, "rd_r4_discarded");

        // Write then read with a later request, then hold on RE=0
        applyStimulus(1, 3'd5, 8'h3C, 0, 3'd0, 3'd0, "wr_r5");
        applyStimulus(0, 3'd0, 8'h00, 1, 3'd5, 3'd2, "rd_r5_r2");
        applyStimulus(1, 3'd5, 8'hEE, 0, 3'd1, 3'd1, "hold_idle");

        // Bypass on both ports to the same register
        applyStimulus(1, 3'd6, 8'h11, 0, 3'd0, 3'd0, "wr_r6");
        applyStimulus(1, 3'd6, 8'h99, 1, 3'd6, 3'd6, "bypass_r6");
        applyStimulus(1, 3'd2, 8'h42, 1, 3'd2, 3'd6, "bypass_a_only");

        // Streaming back-to-back reads
        for (int i = 0; i < 8; i++)
            applyStimulus(1, 3'(i), 8'(8'h10 + i), 0, 3'd0, 3'd0, "stream_wr");
        for (int i = 0; i < 8; i++)
            applyStimulus(0, 3'd0, 8'h00, 1, 3'(i), 3'(7 - i), "stream_rd");
        applyStimulus(0, 3'd0, 8'h00, 0, 3'd0, 3'd0, "stream_end");

        // Register 0 behaviour, plain write/read and bypass
        applyStimulus(1, 3'd0, 8'hFF, 0, 3'd0, 3'd0, "wr_r0");
        applyStimulus(0, 3'd0, 8'h00, 1, 3'd0, 3'd0, "rd_r0");
        checks++;
        assert (RDATA_A === (ZERO_HW ? 8'h00 : 8'hFF)) else begin
            errors++;
            $error("[TB] FAIL r0_const observed=%h expected=%h", RDATA_A,
                   ZERO_HW ? 8'h00 : 8'hFF);
        end
        applyStimulus(1, 3'd0, 8'h5A, 1, 3'd0, 3'd1, "bypass_r0");

        // Random traffic against the model
        for (int i = 0; i < 300; i++)
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom),
                          1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom),
                          "random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_rd.md
Name: reg_file_rd

Overview:
- Register file for the RISC datapath. Stores 8 words written by the writeback stage on rising CLK edges.
- Serves the decode stage through two registered read ports with a valid strobe and write-to-read bypass.
- It is the reader end of the processor's edge-triggered storage: writeback writes, decode reads with a 1-cycle latency.

Parameters:
- DATA_W, 8, word width in bits
- ADDR_W, 3, register address width
- NREGS, 8, number of registers, equal to 2**ADDR_W

Ports:
- CLK  input  1  system clock; all state updates on the rising edge
- RST  input  1  asynchronous, active-high reset
- WE  input  1  write enable from writeback
- WADDR  input  ADDR_W  write register index
- WDATA  input  DATA_W  write data
- RE  input  1  read request from decode
- RADDR_A  input  ADDR_W  read port A index
- RADDR_B  input  ADDR_W  read port B index
- RDATA_A  output  DATA_W  registered read data, port A
- RDATA_B  output  DATA_W  registered read data, port B
- RVALID  output  1  high for one cycle when RDATA_A/RDATA_B hold a new read result

Behaviour:
- Reset:
  - RST high clears all NREGS registers, RDATA_A, RDATA_B and RVALID to 0 immediately, without waiting for CLK.
  - RST deasserting mid-cycle takes effect at the next rising edge.
  - A read or write in flight when RST asserts is discarded.
- Write:
  - At a rising edge with WE=1, reg[WADDR] <= WDATA.
  - WE=0 leaves all registers unchanged.
- Read:
  - At a rising edge with RE=1, RDATA_A <= value(RADDR_A), RDATA_B <= value(RADDR_B), and RVALID <= 1.
  - Latency is exactly 1 cycle from the request edge.
  - RE=0 leaves RDATA_A/RDATA_B holding their last values and sets RVALID <= 0.
  - Back-to-back RE gives RVALID high on consecutive cycles, one new result per cycle.
- Bypass (simultaneous events):
  - If WE=1, RE=1 and WADDR==RADDR_A at the same edge, RDATA_A takes WDATA, never the stale stored value. Port B follows the same rule independently.
  - Both ports may address the same register; both then return identical data.
- No internal state machine beyond storage, read-output registers and RVALID. RVALID is a 1-bit registered copy of RE, forced to 0 by reset.
- Arithmetic and width:
  - No arithmetic.
  - Addresses are always in range because NREGS == 2**ADDR_W.
  - Data passes through unmodified at the full DATA_W width.

Optional Feature:
- Macro: REG_ZERO_HARDWIRED_EN
- Defined:
  - Register 0 always reads 0; writes with WADDR==0 are ignored.
  - Bypass to a read of address 0 also returns 0.
  - Register 0 needs no storage.
- Undefined: register 0 is an ordinary read/write register like the others.

Decomposition:
- Shared package holds:
  - DATA_W and ADDR_W defaults
  - NREGS
  - the register-index constant REG_ZERO = 0
  - the reset data constant DATA_RST = 0
- Natural sub-module: reg_word. One DATA_W-wide storage word with write-enable, asynchronous active-high clear, and capture on the rising CLK edge.
  - reg_file_rd instantiates NREGS copies of reg_word, or NREGS-1 when REG_ZERO_HARDWIRED_EN is defined.
  - Read muxes and bypass compare sit in reg_file_rd.

Test Plan:
- Reset: assert RST mid-cycle after writing 0xA5 to r3 -> RDATA_A, RDATA_B and RVALID go to 0 before the next edge. Then read r3 on both ports -> 0x00, with RVALID=1 one cycle after the RE edge.
- Write/read: write 0x3C to r5, then a later cycle RE=1 with RADDR_A=5, RADDR_B=2 -> next cycle RDATA_A=0x3C, RDATA_B=0x00, RVALID=1. The following cycle, with RE=0 -> RVALID=0 and data held.
- Bypass: r6=0x11; same edge WE=1, WADDR=6, WDATA=0x99, RE=1, RADDR_A=6, RADDR_B=6 -> RDATA_A=RDATA_B=0x99.
- Streaming: write r0..r7 with 0x10..0x17, then RE=1 for 8 consecutive cycles with RADDR_A=i, RADDR_B=7-i -> RVALID stays high for 8 cycles, and each result pair is (0x10+i, 0x17-i).
- Optional feature: write 0xFF to r0, then read r0 -> 0x00 when REG_ZERO_HARDWIRED_EN is defined, 0xFF when it is undefined. Also check bypass on r0 under both builds.
